// File: rtl/reorder_buffer_pkg.sv
// Shared parameters, entry layout and nick/index helpers for the reorder buffer.
// Nick = entry index + 1; nick 0 means "no dependency".
package reorder_buffer_pkg;

  localparam int ROB_SIZE = 16;
  localparam int NICK_W   = 5;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = 5;
  localparam int NAME_W   = 5;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;

  typedef struct packed {
    logic              has_rd;
    logic [NAME_W-1:0] rd;
    logic              is_br;
    logic              is_st;
    logic              pd;
    logic              jmp;
    logic [DATA_W-1:0] dt;
    logic [ADDR_W-1:0] tgt;
  } rob_entry_t;

  function automatic logic [IDX_W-1:0] nick_to_idx(input logic [NICK_W-1:0] nick);
    return IDX_W'(nick - NICK_W'(1));
  endfunction

  function automatic logic [NICK_W-1:0] idx_to_nick(input logic [IDX_W-1:0] idx);
    return NICK_W'(idx) + NICK_W'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer_rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer, including wrap and
// the flush that empties the buffer on a committed mispredict.
module rob_ptr_ctrl
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_req,
  input  logic             head_ready,
  input  logic             flush,
  output logic [IDX_W-1:0] head,
  output logic [IDX_W-1:0] tail,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             alloc_fire,
  output logic             commit_fire
);

  assign full  = (count == CNT_W'(ROB_SIZE));
  assign empty = (count == '0);

  // Full is judged on the pre-commit count, so a commit never frees a slot for
  // an allocation in the same cycle; a flush throws the allocation away.
  assign alloc_fire  = alloc_req & rdy & ~full & ~flush;
  assign commit_fire = rdy & ~empty & head_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (commit_fire)
        head <= (head == IDX_W'(ROB_SIZE - 1)) ? '0 : head + IDX_W'(1);
      if (alloc_fire)
        tail <= (tail == IDX_W'(ROB_SIZE - 1)) ? '0 : tail + IDX_W'(1);
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates nicks, captures CDB results, commits in
// program order and flushes on branch mispredict. Optional operand forwarding
// is enabled by defining ROB_FWD_EN.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              iDP_en,
  input  logic [NAME_W-1:0] iDP_rd_regnm,
  input  logic              iDP_has_rd,
  input  logic              iDP_is_br,
  input  logic              iDP_is_st,
  input  logic              iDP_pd,
  output logic [NICK_W-1:0] oDP_nick,
  output logic              oDP_full,
`ifdef ROB_FWD_EN
  input  logic [NICK_W-1:0] iDP_q1_nick,
  input  logic [NICK_W-1:0] iDP_q2_nick,
  output logic              oDP_q1_rdy,
  output logic              oDP_q2_rdy,
  output logic [DATA_W-1:0] oDP_q1_dt,
  output logic [DATA_W-1:0] oDP_q2_dt,
`endif
  output logic              oRF_nick_en,
  output logic [NAME_W-1:0] oRF_nick_regnm,
  output logic [NICK_W-1:0] oRF_nick,
  input  logic              iCDB_en,
  input  logic [NICK_W-1:0] iCDB_nick,
  input  logic [DATA_W-1:0] iCDB_dt,
  input  logic              iCDB_jmp,
  input  logic [ADDR_W-1:0] iCDB_tgt,
  output logic              oRF_en,
  output logic [NAME_W-1:0] oRF_rd_regnm,
  output logic [DATA_W-1:0] oRF_rd_dt,
  output logic [NICK_W-1:0] oRF_rd_nick,
  output logic              oLSB_st_en,
  output logic [NICK_W-1:0] oLSB_st_nick,
  output logic              oclr,
  output logic [ADDR_W-1:0] oIF_pc
);

  rob_entry_t          ent [ROB_SIZE];
  logic [ROB_SIZE-1:0] valid;
  logic [ROB_SIZE-1:0] ready;

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             alloc_fire;
  logic             commit_fire;
  logic             head_ready;
  logic             mispredict;
  logic             flush;
  logic [IDX_W-1:0] cdb_idx;
  logic             cdb_hit;
  rob_entry_t       head_ent;

  assign head_ent   = ent[head];
  assign head_ready = valid[head] & ready[head];
  assign mispredict = head_ent.is_br & (head_ent.jmp != head_ent.pd);
  assign flush      = commit_fire & mispredict;

  assign cdb_idx = nick_to_idx(iCDB_nick);
  assign cdb_hit = iCDB_en & (iCDB_nick != '0) & (iCDB_nick <= NICK_W'(ROB_SIZE)) & valid[cdb_idx];

  rob_ptr_ctrl u_ptr (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .alloc_req   (iDP_en),
    .head_ready  (head_ready),
    .flush       (flush),
    .head        (head),
    .tail        (tail),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .alloc_fire  (alloc_fire),
    .commit_fire (commit_fire)
  );

  assign oDP_nick = idx_to_nick(tail);
  assign oDP_full = full;

  always_comb begin
    oRF_nick_en    = 1'b0;
    oRF_nick_regnm = '0;
    oRF_nick       = '0;
    if (alloc_fire && iDP_has_rd && (iDP_rd_regnm != '0)) begin
      oRF_nick_en    = 1'b1;
      oRF_nick_regnm = iDP_rd_regnm;
      oRF_nick       = idx_to_nick(tail);
    end
  end

  // Commit clears the head before alloc/CDB update; they never alias because
  // alloc is refused when full and CDB only targets live entries.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
      ready <= '0;
    end else if (rdy) begin
      if (commit_fire) begin
        valid[head] <= 1'b0;
        ready[head] <= 1'b0;
      end
      if (alloc_fire) begin
        valid[tail] <= 1'b1;
        ready[tail] <= 1'b0;
      end
      if (cdb_hit)
        ready[cdb_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      if (alloc_fire) begin
        ent[tail].has_rd <= iDP_has_rd;
        ent[tail].rd     <= iDP_rd_regnm;
        ent[tail].is_br  <= iDP_is_br;
        ent[tail].is_st  <= iDP_is_st;
        ent[tail].pd     <= iDP_pd;
      end
      if (cdb_hit) begin
        ent[cdb_idx].dt  <= iCDB_dt;
        ent[cdb_idx].jmp <= iCDB_jmp;
        ent[cdb_idx].tgt <= iCDB_tgt;
      end
    end
  end

  // Commit outputs hold for exactly one cycle after the deciding edge.
  always_ff @(posedge clk) begin
    oRF_en       <= 1'b0;
    oRF_rd_regnm <= '0;
    oRF_rd_dt    <= '0;
    oRF_rd_nick  <= '0;
    oLSB_st_en   <= 1'b0;
    oLSB_st_nick <= '0;
    oclr         <= 1'b0;
    oIF_pc       <= '0;
    if (!rst && commit_fire) begin
      if (head_ent.has_rd && (head_ent.rd != '0)) begin
        oRF_en       <= 1'b1;
        oRF_rd_regnm <= head_ent.rd;
        oRF_rd_dt    <= head_ent.dt;
        oRF_rd_nick  <= idx_to_nick(head);
      end
      if (head_ent.is_st) begin
        oLSB_st_en   <= 1'b1;
        oLSB_st_nick <= idx_to_nick(head);
      end
      if (mispredict) begin
        oclr   <= 1'b1;
        oIF_pc <= head_ent.tgt;
      end
    end
  end

`ifdef ROB_FWD_EN
  logic [IDX_W-1:0] q1_idx;
  logic [IDX_W-1:0] q2_idx;

  assign q1_idx = nick_to_idx(iDP_q1_nick);
  assign q2_idx = nick_to_idx(iDP_q2_nick);

  // A result on the CDB this cycle wins over the (not yet updated) entry.
  always_comb begin
    oDP_q1_rdy = 1'b0;
    oDP_q1_dt  = '0;
    oDP_q2_rdy = 1'b0;
    oDP_q2_dt  = '0;
    if ((iDP_q1_nick != '0) && (iDP_q1_nick <= NICK_W'(ROB_SIZE))) begin
      if (iCDB_en && (iCDB_nick == iDP_q1_nick)) begin
        oDP_q1_rdy = 1'b1;
        oDP_q1_dt  = iCDB_dt;
      end else if (valid[q1_idx] && ready[q1_idx]) begin
        oDP_q1_rdy = 1'b1;
        oDP_q1_dt  = ent[q1_idx].dt;
      end
    end
    if ((iDP_q2_nick != '0) && (iDP_q2_nick <= NICK_W'(ROB_SIZE))) begin
      if (iCDB_en && (iCDB_nick == iDP_q2_nick)) begin
        oDP_q2_rdy = 1'b1;
        oDP_q2_dt  = iCDB_dt;
      end else if (valid[q2_idx] && ready[q2_idx]) begin
        oDP_q2_rdy = 1'b1;
        oDP_q2_dt  = ent[q2_idx].dt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: allocation/full, in-order
// commit, wrap, mispredict flush, store/x0 commits and rdy stall.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        iDP_en;
  logic [4:0]  iDP_rd_regnm;
  logic        iDP_has_rd;
  logic        iDP_is_br;
  logic        iDP_is_st;
  logic        iDP_pd;
  logic [4:0]  oDP_nick;
  logic        oDP_full;
  logic        oRF_nick_en;
  logic [4:0]  oRF_nick_regnm;
  logic [4:0]  oRF_nick;
  logic        iCDB_en;
  logic [4:0]  iCDB_nick;
  logic [31:0] iCDB_dt;
  logic        iCDB_jmp;
  logic [31:0] iCDB_tgt;
  logic        oRF_en;
  logic [4:0]  oRF_rd_regnm;
  logic [31:0] oRF_rd_dt;
  logic [4:0]  oRF_rd_nick;
  logic        oLSB_st_en;
  logic [4:0]  oLSB_st_nick;
  logic        oclr;
  logic [31:0] oIF_pc;
`ifdef ROB_FWD_EN
  logic [4:0]  iDP_q1_nick = '0;
  logic [4:0]  iDP_q2_nick = '0;
  logic        oDP_q1_rdy;
  logic        oDP_q2_rdy;
  logic [31:0] oDP_q1_dt;
  logic [31:0] oDP_q2_dt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  reorder_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .iDP_en         (iDP_en),
    .iDP_rd_regnm   (iDP_rd_regnm),
    .iDP_has_rd     (iDP_has_rd),
    .iDP_is_br      (iDP_is_br),
    .iDP_is_st      (iDP_is_st),
    .iDP_pd         (iDP_pd),
    .oDP_nick       (oDP_nick),
    .oDP_full       (oDP_full),
`ifdef ROB_FWD_EN
    .iDP_q1_nick    (iDP_q1_nick),
    .iDP_q2_nick    (iDP_q2_nick),
    .oDP_q1_rdy     (oDP_q1_rdy),
    .oDP_q2_rdy     (oDP_q2_rdy),
    .oDP_q1_dt      (oDP_q1_dt),
    .oDP_q2_dt      (oDP_q2_dt),
`endif
    .oRF_nick_en    (oRF_nick_en),
    .oRF_nick_regnm (oRF_nick_regnm),
    .oRF_nick       (oRF_nick),
    .iCDB_en        (iCDB_en),
    .iCDB_nick      (iCDB_nick),
    .iCDB_dt        (iCDB_dt),
    .iCDB_jmp       (iCDB_jmp),
    .iCDB_tgt       (iCDB_tgt),
    .oRF_en         (oRF_en),
    .oRF_rd_regnm   (oRF_rd_regnm),
    .oRF_rd_dt      (oRF_rd_dt),
    .oRF_rd_nick    (oRF_rd_nick),
    .oLSB_st_en     (oLSB_st_en),
    .oLSB_st_nick   (oLSB_st_nick),
    .oclr           (oclr),
    .oIF_pc         (oIF_pc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic dp(input logic [4:0] rd, input logic has_rd, input logic is_br,
                    input logic is_st, input logic pd);
    iDP_en       = 1'b1;
    iDP_rd_regnm = rd;
    iDP_has_rd   = has_rd;
    iDP_is_br    = is_br;
    iDP_is_st    = is_st;
    iDP_pd       = pd;
  endtask

  task automatic cdb(input logic [4:0] nick, input logic [31:0] dt,
                     input logic jmp, input logic [31:0] tgt);
    iCDB_en   = 1'b1;
    iCDB_nick = nick;
    iCDB_dt   = dt;
    iCDB_jmp  = jmp;
    iCDB_tgt  = tgt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rdy = 1'b1; iDP_en = 1'b0; iDP_rd_regnm = '0; iDP_has_rd = 1'b0;
    iDP_is_br = 1'b0; iDP_is_st = 1'b0; iDP_pd = 1'b0;
    iCDB_en = 1'b0; iCDB_nick = '0; iCDB_dt = '0; iCDB_jmp = 1'b0; iCDB_tgt = '0;
    do_reset();
    settle();

    // reset state
    chk("rst_nick", oDP_nick, 1);
    chk("rst_full", oDP_full, 0);
    chk("rst_rf_en", oRF_en, 0);
    chk("rst_clr", oclr, 0);
    chk("rst_st_en", oLSB_st_en, 0);
    chk("rst_nick_en", oRF_nick_en, 0);

    // 1: fill with x1..x16, then a 17th request is ignored
    for (int i = 1; i <= 16; i++) begin
      dp(5'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      settle();
      chk($sformatf("alloc%0d_nick", i), oDP_nick, i);
      chk($sformatf("alloc%0d_ren_nick", i), oRF_nick, i);
      chk($sformatf("alloc%0d_ren_reg", i), oRF_nick_regnm, i);
      chk($sformatf("alloc%0d_ren_en", i), oRF_nick_en, 1);
      step();
    end
    chk("full_after16", oDP_full, 1);
    chk("nick_wrapped", oDP_nick, 1);
    dp(5'd17, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("alloc17_ren_en", oRF_nick_en, 0);
    step();
    iDP_en = 1'b0;
    chk("alloc17_still_full", oDP_full, 1);
    chk("no_commit_yet", oRF_en, 0);

    // 2: out-of-order completion, in-order commit
    cdb(5'd3, 32'h333, 1'b0, '0); step();
    chk("nick3_not_committed", oRF_en, 0);
    cdb(5'd1, 32'h111, 1'b0, '0); step();
    chk("commit_before_ready", oRF_en, 0);
    cdb(5'd2, 32'h222, 1'b0, '0); step();
    iCDB_en = 1'b0;
    chk("c1_en", oRF_en, 1);
    chk("c1_nick", oRF_rd_nick, 1);
    chk("c1_reg", oRF_rd_regnm, 1);
    chk("c1_dt", oRF_rd_dt, 32'h111);
    step();
    chk("c2_en", oRF_en, 1);
    chk("c2_nick", oRF_rd_nick, 2);
    chk("c2_dt", oRF_rd_dt, 32'h222);
    step();
    chk("c3_en", oRF_en, 1);
    chk("c3_nick", oRF_rd_nick, 3);
    chk("c3_reg", oRF_rd_regnm, 3);
    chk("c3_dt", oRF_rd_dt, 32'h333);
    step();
    chk("c4_pulse_end", oRF_en, 0);
    chk("c4_nick_zero", oRF_rd_nick, 0);

    // 3: refill across the wrap; full with ready head refuses alloc
    for (int i = 0; i < 3; i++) begin
      dp(5'(20 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      settle();
      chk($sformatf("wrap_alloc%0d_nick", i), oDP_nick, i + 1);
      step();
    end
    iDP_en = 1'b0;
    chk("refull", oDP_full, 1);
    chk("refull_nick", oDP_nick, 4);
    cdb(5'd4, 32'h444, 1'b0, '0); step();
    iCDB_en = 1'b0;
    dp(5'd23, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("full_refuse_full", oDP_full, 1);
    chk("full_refuse_ren", oRF_nick_en, 0);
    step();
    chk("full_commit_en", oRF_en, 1);
    chk("full_commit_nick", oRF_rd_nick, 4);
    chk("full_commit_dt", oRF_rd_dt, 32'h444);
    chk("after_commit_full", oDP_full, 0);
    chk("after_commit_nick", oDP_nick, 4);
    settle();
    chk("retry_ren_en", oRF_nick_en, 1);
    chk("retry_ren_nick", oRF_nick, 4);
    step();
    iDP_en = 1'b0;
    chk("retry_full", oDP_full, 1);
    chk("retry_no_commit", oRF_en, 0);

    // 4: mispredicted branch flushes everything
    do_reset();
    settle();
    chk("rst2_nick", oDP_nick, 1);
    chk("rst2_rf_en", oRF_en, 0);
    dp(5'd0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    dp(5'd7, 1'b1, 1'b0, 1'b0, 1'b0); step();
    dp(5'd8, 1'b1, 1'b0, 1'b0, 1'b0); step();
    iDP_en = 1'b0;
    cdb(5'd2, 32'h77, 1'b0, '0); step();
    cdb(5'd1, 32'h0, 1'b1, 32'h1040); step();
    iCDB_en = 1'b0;
    dp(5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("flush_cycle_nick", oDP_nick, 4);
    chk("flush_cycle_ren", oRF_nick_en, 0);
    step();
    iDP_en = 1'b0;
    chk("clr", oclr, 1);
    chk("clr_pc", oIF_pc, 32'h1040);
    chk("clr_rf_en", oRF_en, 0);
    chk("clr_nick", oDP_nick, 1);
    chk("clr_full", oDP_full, 0);
    step();
    chk("clr_pulse_end", oclr, 0);
    chk("clr_pc_end", oIF_pc, 0);
    chk("flushed_entry_gone", oRF_en, 0);
    step();
    chk("flushed_entry_gone2", oRF_en, 0);

    // 5: store, rd=x0 add, correctly predicted jal-like branch
    dp(5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("st_nick", oDP_nick, 1);
    chk("st_ren", oRF_nick_en, 0);
    step();
    dp(5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("x0_nick", oDP_nick, 2);
    chk("x0_ren", oRF_nick_en, 0);
    step();
    dp(5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    settle();
    chk("br_ren_en", oRF_nick_en, 1);
    chk("br_ren_nick", oRF_nick, 3);
    step();
    iDP_en = 1'b0;
    cdb(5'd1, 32'h0, 1'b0, '0); step();
    cdb(5'd2, 32'h55, 1'b0, '0); step();
    chk("st_commit_en", oLSB_st_en, 1);
    chk("st_commit_nick", oLSB_st_nick, 1);
    chk("st_commit_rf", oRF_en, 0);
    cdb(5'd3, 32'h1004, 1'b1, 32'h2000); step();
    iCDB_en = 1'b0;
    chk("x0_commit_rf", oRF_en, 0);
    chk("x0_commit_st", oLSB_st_en, 0);
    step();
    chk("br_ok_rf_en", oRF_en, 1);
    chk("br_ok_reg", oRF_rd_regnm, 5);
    chk("br_ok_dt", oRF_rd_dt, 32'h1004);
    chk("br_ok_nick", oRF_rd_nick, 3);
    chk("br_ok_clr", oclr, 0);

    // 6: rdy low freezes commit and alloc
    dp(5'd10, 1'b1, 1'b0, 1'b0, 1'b0); step();
    iDP_en = 1'b0;
    cdb(5'd4, 32'hAAA, 1'b0, '0); step();
    iCDB_en = 1'b0;
    rdy = 1'b0;
    dp(5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("stall_ren", oRF_nick_en, 0);
    step();
    chk("stall_rf_en", oRF_en, 0);
    chk("stall_nick", oDP_nick, 5);
    step();
    chk("stall_rf_en2", oRF_en, 0);
    iDP_en = 1'b0;
    rdy = 1'b1;
    step();
    chk("resume_en", oRF_en, 1);
    chk("resume_nick", oRF_rd_nick, 4);
    chk("resume_reg", oRF_rd_regnm, 10);
    chk("resume_dt", oRF_rd_dt, 32'hAAA);
    step();
    chk("resume_pulse_end", oRF_en, 0);
    chk("resume_tail", oDP_nick, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
